// File: rtl/imem_fetch_sequencer.sv
// rtl/imem_fetch_sequencer.sv - instruction fetch sequencer with one-entry output slot
module imem_fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [1:0]  ST_RUN    = 2'd0;
  localparam logic [1:0]  ST_HALT   = 2'd1;
  localparam logic [1:0]  ST_FAULT  = 2'd2;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  logic [1:0]  state;
  logic [31:0] pc;
  logic        handshake;
  logic        slot_free;
  logic        in_range;
  logic        redirect_taken;
  logic        redirect_aligned;

  assign imem_addr = pc;

  // Decode of the per-cycle conditions that steer the sequencer
  always_comb begin
    handshake        = out_valid & out_ready;
    slot_free        = ~out_valid | out_ready;
    in_range         = (pc < MEM_BYTES);
    redirect_taken   = redirect_valid & (state != ST_FAULT);
    redirect_aligned = (redirect_pc[1:0] == 2'b00);
  end

  // Count every accepted slot, independent of what else happens that cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'd0;
    end else if (handshake) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  // Program counter, output slot and RUN/HALT/FAULT sequencing; redirect beats fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      state     <= ST_RUN;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_pc    <= 32'd0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else if (redirect_taken) begin
      // Any redirect flushes the slot, even one decode has not yet taken
      out_valid <= 1'b0;
      if (redirect_aligned) begin
        pc     <= redirect_pc;
        state  <= ST_RUN;
        halted <= 1'b0;
      end else begin
        state  <= ST_FAULT;
        fault  <= 1'b1;
        halted <= 1'b1;
      end
    end else if (state == ST_RUN && slot_free) begin
      if (in_range) begin
        out_instr <= imem_instr;
        out_pc    <= pc;
        out_valid <= 1'b1;
        pc        <= pc + 32'd4;
      end else begin
        // Ran off the end of memory: stop and wait for a redirect
        out_valid <= 1'b0;
        state     <= ST_HALT;
        halted    <= 1'b1;
      end
    end else if (state != ST_RUN) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// tb/tb_imem_fetch_sequencer.sv - scoreboard bench for imem_fetch_sequencer
module tb_imem_fetch_sequencer;

  localparam int          MEM_WORDS = 64;
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  imem_fetch_sequencer #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] prog [6];

  always_comb begin
    if (imem_addr < MEM_BYTES) imem_instr = mem[imem_addr[AW+1:2]];
    else                       imem_instr = 32'hbad0_0bad;
  end

  // Reference model: the sequence of (pc, instr) decode should still receive,
  // plus the sticky fault flag and the number of accepted handshakes.
  logic [63:0] exp_q [$];
  logic        m_fault;
  logic [31:0] m_count;
  bit          started = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem[a[AW+1:2]];
  endfunction

  task automatic rebuild(input logic [31:0] start);
    exp_q.delete();
    for (longint a = longint'(start); a < longint'(MEM_BYTES); a += 4)
      exp_q.push_back({a[31:0], mem_word(a[31:0])});
  endtask

  task automatic model_update(input logic rst, input logic rv, input logic [31:0] rpc);
    if (rst) begin
      started = 1;
      m_fault = 1'b0;
      m_count = 32'd0;
      rebuild(RESET_PC);
    end else if (rv && !m_fault) begin
      if (rpc[1:0] == 2'b00) begin
        rebuild(rpc);
      end else begin
        m_fault = 1'b1;
        exp_q.delete();
      end
    end
  endtask

  // One cycle of stimulus: drive, let the edge consume it, update the model
  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    model_update(rst, rv, rpc);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake, mid-cycle
  always @(negedge clk) begin
    logic [63:0] e;
    if (started) begin
      check("fetch_count", fetch_count, m_count);
      check("fault", {31'd0, fault}, {31'd0, m_fault});
      if (halted) check("halted_drained", {31'd0, (exp_q.size() == 0) && !out_valid}, 32'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: out_pc %h while no output was required", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e[63:32]);
          check("out_instr", out_instr, e[31:0]);
          m_count = m_count + 32'd1;
        end
      end
    end
  end

  initial begin
    logic        rst, rv, rdy;
    logic [31:0] rpc;
    int          r;

    prog[0] = 32'h20080008; prog[1] = 32'h20090003; prog[2] = 32'h01095020;
    prog[3] = 32'h01095822; prog[4] = 32'hac0a0000; prog[5] = 32'hac0b0004;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = (i < 6) ? prog[i] : $urandom;

    // Reset values
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);

    // Straight-line, one word per cycle
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      check("line_valid", {31'd0, out_valid}, 32'd1);
      check("line_pc", out_pc, 32'(i * 4));
      check("line_instr", out_instr, prog[i]);
    end
    step(0, 0, 0, 1);
    check("line_count", fetch_count, 32'd6);

    // Backpressure holds the slot and pc
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_pc", out_pc, 32'h4);
      check("bp_instr", out_instr, 32'h20090003);
      check("bp_addr", imem_addr, 32'h8);
    end
    step(0, 0, 0, 1);
    check("bp_resume_pc", out_pc, 32'h8);
    check("bp_resume_instr", out_instr, 32'h01095020);

    // Redirect flushes an unaccepted slot
    step(0, 1, 32'h10, 0);
    check("redir_flush", {31'd0, out_valid}, 32'd0);
    check("redir_count", fetch_count, 32'd2);
    step(0, 0, 0, 0);
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    check("redir_pc", out_pc, 32'h10);
    check("redir_instr", out_instr, 32'hac0a0000);

    // End of memory
    step(1, 0, 0, 1);
    for (int i = 0; i < MEM_WORDS; i++) step(0, 0, 0, 1);
    check("eom_last_pc", out_pc, MEM_BYTES - 32'd4);
    check("eom_last_valid", {31'd0, out_valid}, 32'd1);
    step(0, 0, 0, 1);
    check("eom_halted", {31'd0, halted}, 32'd1);
    check("eom_valid", {31'd0, out_valid}, 32'd0);
    check("eom_count", fetch_count, 32'(MEM_WORDS));
    step(0, 1, 32'h0, 1);
    check("eom_unhalt", {31'd0, halted}, 32'd0);
    step(0, 0, 0, 1);
    check("eom_refetch_pc", out_pc, 32'h0);
    check("eom_refetch_instr", out_instr, 32'h20080008);

    // Misaligned redirect faults; fault absorbs redirects until reset
    step(0, 1, 32'h6, 1);
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_halted", {31'd0, halted}, 32'd1);
    check("mis_valid", {31'd0, out_valid}, 32'd0);
    step(0, 1, 32'h0, 1);
    check("mis_ignored_addr", imem_addr, 32'h4);
    check("mis_ignored_valid", {31'd0, out_valid}, 32'd0);
    step(1, 0, 0, 1);
    check("mis_rst_fault", {31'd0, fault}, 32'd0);
    check("mis_rst_halted", {31'd0, halted}, 32'd0);
    check("mis_rst_count", fetch_count, 32'd0);
    check("mis_rst_addr", imem_addr, RESET_PC);
    step(0, 0, 0, 1);
    check("mis_restart_pc", out_pc, RESET_PC);

    // Reset and redirect together: reset wins
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 1, 32'h20, 1);
    check("coll_addr", imem_addr, RESET_PC);
    check("coll_valid", {31'd0, out_valid}, 32'd0);
    check("coll_count", fetch_count, 32'd0);
    step(0, 0, 0, 1);
    check("coll_restart_pc", out_pc, RESET_PC);

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rst = m_fault ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 399) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      r   = $urandom_range(0, 19);
      if (r == 0)      rpc = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
      else if (r < 3)  rpc = {$urandom_range(64, 80), 2'b00};
      else             rpc = {$urandom_range(0, 63), 2'b00};
      step(rst, rv, rpc, rdy);
    end

    // Drain to the end of memory
    if (m_fault) step(1, 0, 0, 1);
    for (int i = 0; i < 200 && !halted; i++) step(0, 0, 0, 1);
    check("drain_halted", {31'd0, halted}, 32'd1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
